rr_arbiter: RTL

Round-robin arbiter that shares one resource among `N_REQ` requesters. Each requester holds `req` high while it needs the resource. The block grants exactly one requester at a time and holds the grant until that owner releases. The winner is chosen by a rotating-priority encode, so no requester starves. It sits between the requester ports and the shared datapath, and drives the datapath's select (`grant_id`) and enable (`grant_valid`).

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Purpose: shared types and constants for the round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 15;

  // Bits needed to hold values 0..n-1; matches $clog2 for n >= 1.
  function automatic int idx_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: rotating-priority encoder, picks first set req bit starting at ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int W     = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic [W-1:0]     idx,
  output logic [N_REQ-1:0] onehot,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [W-1:0]       off;

  // Rotate right by ptr so bit 0 of rot is the highest-priority requester.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
  end

  // Lowest set bit of the rotated vector, then undo the rotation.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    idx    = off + ptr;
    onehot = N_REQ'(1) << idx;
    any    = |req;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter with held grants; optional hold limit via ARB_TIMEOUT_EN.
// Latency: grant visible 1 cycle after req sampled in IDLE; release clears after 1 cycle.
// Backpressure: owner keeps the grant until done or req drop; one dead cycle per handover.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic                      done,
  output logic [N_REQ-1:0]          grant,
  output logic [idx_w(N_REQ)-1:0]   grant_id,
  output logic                      grant_valid,
  output logic                      timeout
);

  localparam int W = idx_w(N_REQ);

  state_t           state;
  logic [W-1:0]     ptr;
  logic [W-1:0]     pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_any;
  logic             release_c;
  logic             force_rel;

  rr_pick #(
    .N_REQ (N_REQ),
    .W     (W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .idx    (pick_idx),
    .onehot (pick_oh),
    .any    (pick_any)
  );

  // Owner gives up the resource explicitly or by dropping its request.
  assign release_c = done | ~req[grant_id];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = idx_w(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;

  // Revoke only when the owner has not released on its own this cycle.
  assign force_rel = ~release_c & (hold_cnt == CW'(MAX_HOLD));
`else
  // MAX_HOLD only matters with the hold counter present.
  logic hold_unused;
  assign hold_unused = (MAX_HOLD > 0);
  assign force_rel   = 1'b0;
`endif

  // Arbitration FSM, priority pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant       <= pick_oh;
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            state       <= BUSY;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= CW'(1);
`endif
          end
        end
        BUSY: begin
          if (release_c || force_rel) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            // Just-served requester drops to lowest priority.
            ptr         <= grant_id + W'(1);
            state       <= IDLE;
            timeout     <= force_rel;
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= hold_cnt + CW'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
